// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic:
// register-zero constant, mult/div sequencer state encoding and default latencies.
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // A producer register hits a consumer operand only when it is not $0.
  function automatic logic reg_hit(
    input logic [4:0] wr,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return (wr != REG_ZERO) && ((wr == rs) || (wr == rt));
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// HI/LO occupancy sequencer: a down-counter plus an IDLE/BUSY FSM,
// with a sticky flag for starts that arrive while the unit is occupied.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done,
  output logic err
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // State, counter and error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state: load on an idle start, count down while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES)
                           : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (start) err_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == BUSY);
    done = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    err  = err_q;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush control for the 5-stage pipeline: catches load-use,
// decode-stage branch operand and HI/LO occupancy hazards.
module pipeline_stall_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic       branch_d,
  input  logic       pcsrc_d,
  input  logic       hilo_use_d,
  input  logic       memtoreg_e,
  input  logic       regwrite_e,
  input  logic [4:0] writereg_e,
  input  logic       memtoreg_m,
  input  logic [4:0] writereg_m,
  input  logic       muldiv_start_e,
  input  logic       muldiv_is_div_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       muldiv_busy,
  output logic       muldiv_done,
  output logic       muldiv_err
);

  logic lwstall;
  logic branchstall;
  logic hilostall;
  logic stall;
  logic ex_rs_unused;

  muldiv_seq #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .start (muldiv_start_e),
    .is_div(muldiv_is_div_e),
    .busy  (muldiv_busy),
    .done  (muldiv_done),
    .err   (muldiv_err)
  );

  // EX-stage sources belong to the forwarding unit, not to stalling.
  assign ex_rs_unused = ^{rs_e, rt_e};

  // Hazard detection and the resulting stall/flush controls.
  always_comb begin
    lwstall = memtoreg_e
            & reg_hit(writereg_e, rs_d, rt_d);
    branchstall = branch_d & (
        (regwrite_e & reg_hit(writereg_e, rs_d, rt_d))
      | (memtoreg_m & reg_hit(writereg_m, rs_d, rt_d)));
    hilostall = hilo_use_d & muldiv_busy;
    stall   = lwstall | branchstall | hilostall;
    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
    // A redirect computed from stale operands must be discarded.
    flush_d = pcsrc_d & ~stall;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vectors plus a
// per-cycle comparison against a cycle-indexed behavioural model.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic       branch_d, pcsrc_d, hilo_use_d;
  logic       memtoreg_e, regwrite_e;
  logic [4:0] writereg_e;
  logic       memtoreg_m;
  logic [4:0] writereg_m;
  logic       muldiv_start_e, muldiv_is_div_e;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic       muldiv_busy, muldiv_done, muldiv_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .rs_e           (rs_e),
    .rt_e           (rt_e),
    .branch_d       (branch_d),
    .pcsrc_d        (pcsrc_d),
    .hilo_use_d     (hilo_use_d),
    .memtoreg_e     (memtoreg_e),
    .regwrite_e     (regwrite_e),
    .writereg_e     (writereg_e),
    .memtoreg_m     (memtoreg_m),
    .writereg_m     (writereg_m),
    .muldiv_start_e (muldiv_start_e),
    .muldiv_is_div_e(muldiv_is_div_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .muldiv_busy    (muldiv_busy),
    .muldiv_done    (muldiv_done),
    .muldiv_err     (muldiv_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: the unit is busy for periods m_per in (start, m_end].
  int m_end = -1;
  int m_per = 0;
  bit m_err = 1'b0;

  function automatic bit m_busy();
    return m_end >= m_per;
  endfunction

  function automatic bit m_done();
    return m_busy() && (m_end == m_per);
  endfunction

  function automatic bit hits(input logic [4:0] w);
    return (w != 5'd0) && (w == rs_d || w == rt_d);
  endfunction

  function automatic bit m_stall();
    bit lw, br, hl;
    lw = memtoreg_e && hits(writereg_e);
    br = branch_d && ((regwrite_e && hits(writereg_e))
                   || (memtoreg_m && hits(writereg_m)));
    hl = hilo_use_d && m_busy();
    return lw || br || hl;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_end = -1;
      m_per = 0;
      m_err = 1'b0;
    end else begin
      if (muldiv_start_e) begin
        if (m_busy()) m_err = 1'b1;
        else m_end = m_per + (muldiv_is_div_e ? 32 : 4);
      end
      m_per++;
    end
  end

  always @(negedge clk) begin
    bit s;
    s = m_stall();
    chk("m_stall_f", int'(stall_f), int'(s));
    chk("m_stall_d", int'(stall_d), int'(s));
    chk("m_flush_e", int'(flush_e), int'(s));
    chk("m_flush_d", int'(flush_d), int'(pcsrc_d && !s));
    chk("m_busy", int'(muldiv_busy), int'(m_busy()));
    chk("m_done", int'(muldiv_done), int'(m_done()));
    chk("m_err", int'(muldiv_err), int'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    branch_d = 0; pcsrc_d = 0; hilo_use_d = 0;
    memtoreg_e = 0; regwrite_e = 0; writereg_e = 0;
    memtoreg_m = 0; writereg_m = 0;
    muldiv_start_e = 0; muldiv_is_div_e = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    chk("rst_busy", int'(muldiv_busy), 0);
    chk("rst_done", int'(muldiv_done), 0);
    chk("rst_err", int'(muldiv_err), 0);
    chk("rst_stall", int'(stall_f), 0);
    #1 reset = 1'b0;

    // Load-use
    tick();
    memtoreg_e = 1; writereg_e = 5'd8; rs_d = 5'd8;
    #1;
    chk("lu_stall_f", int'(stall_f), 1);
    chk("lu_stall_d", int'(stall_d), 1);
    chk("lu_flush_e", int'(flush_e), 1);
    chk("lu_flush_d", int'(flush_d), 0);
    tick();
    writereg_e = 5'd0; rs_d = 5'd0;
    #1;
    chk("lu0_stall", int'(stall_f), 0);
    chk("lu0_flush_e", int'(flush_e), 0);
    tick();
    clear_in();

    // Branch with ALU result in EX
    tick();
    branch_d = 1; pcsrc_d = 1;
    regwrite_e = 1; writereg_e = 5'd9; rt_d = 5'd9;
    #1;
    chk("br_e_stall", int'(stall_d), 1);
    chk("br_e_flush_d", int'(flush_d), 0);
    tick();
    regwrite_e = 0;
    #1;
    chk("br_e2_stall", int'(stall_d), 0);
    chk("br_e2_flush_d", int'(flush_d), 1);

    // Branch with load in MEM
    tick();
    memtoreg_m = 1; writereg_m = 5'd9;
    #1;
    chk("br_m_stall", int'(stall_d), 1);
    chk("br_m_flush_d", int'(flush_d), 0);
    tick();
    memtoreg_m = 0;
    #1;
    chk("br_m2_stall", int'(stall_d), 0);
    chk("br_m2_flush_d", int'(flush_d), 1);
    tick();
    clear_in();

    // Mult timing with hilo use held
    tick();
    muldiv_start_e = 1; muldiv_is_div_e = 0; hilo_use_d = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      muldiv_start_e = 0;
      #1;
      chk("mul_busy", int'(muldiv_busy), int'(i <= 4));
      chk("mul_done", int'(muldiv_done), int'(i == 4));
      chk("mul_stall", int'(stall_f), int'(i <= 4));
    end
    clear_in();

    // Div timing, back-to-back start after done
    tick();
    muldiv_start_e = 1; muldiv_is_div_e = 1;
    for (int i = 1; i <= 66; i++) begin
      tick();
      muldiv_start_e = (i == 33);
      muldiv_is_div_e = 1;
      #1;
      chk("div_busy", int'(muldiv_busy),
          int'((i >= 1 && i <= 32) || (i >= 34 && i <= 65)));
      chk("div_done", int'(muldiv_done), int'(i == 32 || i == 65));
    end
    chk("div_err", int'(muldiv_err), 0);
    clear_in();

    // Illegal start while busy
    tick();
    muldiv_start_e = 1; muldiv_is_div_e = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      muldiv_start_e = (i == 2);
      muldiv_is_div_e = 1;
      #1;
      chk("ill_err", int'(muldiv_err), int'(i >= 3));
      chk("ill_busy", int'(muldiv_busy), int'(i <= 4));
    end
    clear_in();

    // Async reset in the middle of a div
    tick();
    muldiv_start_e = 1; muldiv_is_div_e = 1; hilo_use_d = 1;
    tick();
    muldiv_start_e = 0;
    #1;
    chk("ar_pre_stall", int'(stall_f), 1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", int'(muldiv_busy), 0);
    chk("ar_done", int'(muldiv_done), 0);
    chk("ar_err", int'(muldiv_err), 0);
    chk("ar_stall", int'(stall_f), 0);
    tick();
    reset = 1'b0;
    clear_in();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
